// File: rtl/bram_window_reader_if.sv
// Bus bundle between the window reader, the BRAM bank pair and the convolution core.
// master is the reader's view; slave is the surrounding system's view.
interface bram_window_reader_if;
    logic        wnd_in_bram;
    logic        bram_low_en;
    logic [31:0] bram_low_addr;
    logic [31:0] bram_low_dout;
    logic        bram_hi_en;
    logic [31:0] bram_hi_addr;
    logic [31:0] bram_hi_dout;
    logic        pixel_ack;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win0;
    logic [71:0] win1;
    logic [8:0]  win_row;
    logic [9:0]  win_col;
    logic        frame_done;

    modport master (
        input  wnd_in_bram,
        input  bram_low_dout,
        input  bram_hi_dout,
        input  win_ready,
        output bram_low_en,
        output bram_low_addr,
        output bram_hi_en,
        output bram_hi_addr,
        output pixel_ack,
        output win_valid,
        output win0,
        output win1,
        output win_row,
        output win_col,
        output frame_done
    );

    modport slave (
        output wnd_in_bram,
        output bram_low_dout,
        output bram_hi_dout,
        output win_ready,
        input  bram_low_en,
        input  bram_low_addr,
        input  bram_hi_en,
        input  bram_hi_addr,
        input  pixel_ack,
        input  win_valid,
        input  win0,
        input  win1,
        input  win_row,
        input  win_col,
        input  frame_done
    );
endinterface

// File: rtl/bram_window_reader.sv
// Sweeps a 3x3 neighbourhood over the BRAM line ring, two windows per column-pair step.
module bram_window_reader #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int RING_ROWS = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_window_reader_if.master bus
);
    localparam int RW    = $clog2(RING_ROWS);
    localparam int STEPS = IMG_W / 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_TOP,
        RD_MID,
        RD_BOT,
        LAST,
        EMIT,
        DONE
    } state_t;

    // rows r-1..r+1 by columns 2k-2..2k+1
    typedef logic [2:0][3:0][7:0] cols_t;

    state_t        state_q;
    logic          armed_q;
    logic [8:0]    r_q;
    logic [8:0]    k_q;
    logic [RW-1:0] top_q;
    logic [7:0]    top_lo_q;
    logic [7:0]    top_hi_q;
    logic [7:0]    mid_lo_q;
    logic [7:0]    mid_hi_q;
    cols_t         cols_q;
    cols_t         cols_d;
    logic          en_q;
    logic [31:0]   lo_addr_q;
    logic [31:0]   hi_addr_q;
    logic          ack_q;
    logic          valid_q;
    logic [71:0]   win0_q;
    logic [71:0]   win1_q;
    logic [8:0]    row_q;
    logic [9:0]    col_q;
    logic          done_q;

    logic [RW-1:0] mid_ring;
    logic [RW-1:0] bot_ring;
    logic [8:0]    k_d;
    logic [8:0]    r_d;
    logic [RW-1:0] top_d;
    logic          frame_end;
    logic          adv_go;
    logic          unused_dout_hi;

    function automatic logic [RW-1:0] ring_inc(input logic [RW-1:0] v);
        return (32'(v) == RING_ROWS - 1) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [31:0] pix_addr(
        input logic [RW-1:0] ring,
        input logic [8:0]    k
    );
        return 32'(ring) * 32'(IMG_W) + {22'd0, k, 1'b0};
    endfunction

    function automatic logic [71:0] pack(input cols_t c, input int off);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w[(i*3+j)*8 +: 8] = c[i][j+off];
            end
        end
        return w;
    endfunction

    assign mid_ring = ring_inc(top_q);
    assign bot_ring = ring_inc(mid_ring);
    assign adv_go   = (state_q == LAST && k_q == '0) ||
                      (state_q == EMIT && bus.win_ready);

    assign unused_dout_hi = ^{bus.bram_low_dout[31:8], bus.bram_hi_dout[31:8]};

    always_comb begin
        k_d       = k_q + 9'd1;
        r_d       = r_q;
        top_d     = top_q;
        frame_end = 1'b0;
        if (32'(k_d) == STEPS) begin
            k_d       = '0;
            r_d       = r_q + 9'd1;
            top_d     = ring_inc(top_q);
            frame_end = (32'(r_d) == IMG_H - 1);
        end
    end

    // the oldest column pair falls out; the freshly read pair enters on the right
    always_comb begin
        cols_d = cols_q;
        for (int i = 0; i < 3; i++) begin
            cols_d[i][0] = cols_q[i][2];
            cols_d[i][1] = cols_q[i][3];
        end
        cols_d[0][2] = top_lo_q;
        cols_d[0][3] = top_hi_q;
        cols_d[1][2] = mid_lo_q;
        cols_d[1][3] = mid_hi_q;
        cols_d[2][2] = bus.bram_low_dout[7:0];
        cols_d[2][3] = bus.bram_hi_dout[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            r_q       <= 9'd1;
            k_q       <= '0;
            top_q     <= '0;
            top_lo_q  <= '0;
            top_hi_q  <= '0;
            mid_lo_q  <= '0;
            mid_hi_q  <= '0;
            cols_q    <= '0;
            en_q      <= 1'b0;
            lo_addr_q <= '0;
            hi_addr_q <= '0;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            win0_q    <= '0;
            win1_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.wnd_in_bram && armed_q) begin
                        state_q   <= RD_TOP;
                        r_q       <= 9'd1;
                        k_q       <= '0;
                        top_q     <= '0;
                        en_q      <= 1'b1;
                        lo_addr_q <= pix_addr('0, '0);
                        hi_addr_q <= pix_addr('0, '0) + 32'd1;
                    end
                end
                RD_TOP: begin
                    state_q   <= RD_MID;
                    lo_addr_q <= pix_addr(mid_ring, k_q);
                    hi_addr_q <= pix_addr(mid_ring, k_q) + 32'd1;
                end
                RD_MID: begin
                    state_q   <= RD_BOT;
                    top_lo_q  <= bus.bram_low_dout[7:0];
                    top_hi_q  <= bus.bram_hi_dout[7:0];
                    lo_addr_q <= pix_addr(bot_ring, k_q);
                    hi_addr_q <= pix_addr(bot_ring, k_q) + 32'd1;
                end
                RD_BOT: begin
                    state_q  <= LAST;
                    mid_lo_q <= bus.bram_low_dout[7:0];
                    mid_hi_q <= bus.bram_hi_dout[7:0];
                    en_q     <= 1'b0;
                    ack_q    <= 1'b1;
                end
                LAST: begin
                    cols_q <= cols_d;
                    if (k_q != '0) begin
                        state_q <= EMIT;
                        valid_q <= 1'b1;
                        win0_q  <= pack(cols_d, 0);
                        win1_q  <= pack(cols_d, 1);
                        row_q   <= r_q;
                        col_q   <= {k_q, 1'b0} - 10'd1;
                    end
                end
                EMIT: begin
                    if (bus.win_ready) begin
                        valid_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    armed_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (adv_go) begin
                k_q   <= k_d;
                r_q   <= r_d;
                top_q <= top_d;
                if (frame_end) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q   <= RD_TOP;
                    en_q      <= 1'b1;
                    lo_addr_q <= pix_addr(top_d, k_d);
                    hi_addr_q <= pix_addr(top_d, k_d) + 32'd1;
                end
            end
            // a low level re-arms, so only a fresh rising edge starts a frame
            if (!bus.wnd_in_bram) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign bus.bram_low_en   = en_q;
    assign bus.bram_hi_en    = en_q;
    assign bus.bram_low_addr = lo_addr_q;
    assign bus.bram_hi_addr  = hi_addr_q;
    assign bus.pixel_ack     = ack_q;
    assign bus.win_valid     = valid_q;
    assign bus.win0          = win0_q;
    assign bus.win1          = win1_q;
    assign bus.win_row       = row_q;
    assign bus.win_col       = col_q;
    assign bus.frame_done    = done_q;
endmodule
